// File: rtl/sfx_scheduler.sv
// -----------------------------------------------------------------------------
// sfx_scheduler
//
// Arbitrates sound-effect requests from four requesters and drives the audio
// player control word. Each request is latched into a per-requester pending
// slot. An idle scheduler grants pending slots round-robin. Every granted
// effect is preceded by a run of GAP_CYCLES cycles with the effect select at
// 0, so the player always sees an edge, even when the same id repeats. The
// effect then plays until the player has consumed the effect's sample count.
// There is no preemption.
//
// Ports
//   clk          single clock
//   reset        synchronous, active-high reset
//   bgm_enable   background music level request (registered to audio_ctrl[2])
//   req_valid    one-cycle request pulse per requester 0..3
//   req_id       effect id of requester i on bits [2i+1:2i]; id 0 = none
//   sample_tick  one pulse per sample consumed by the player
//   audio_ctrl   {bgm enable, effect select[1:0]}
//   sfx_active   high while an effect is playing
//   pending      per-requester pending flags
//   drop_count   overwritten requests, saturating at 255
//
// GAP_CYCLES must be at least 1 and every LENn must be at least 1.
// -----------------------------------------------------------------------------
module sfx_scheduler #(
    parameter int unsigned GAP_CYCLES = 4,
    parameter logic [15:0] LEN1       = 16'h156A,
    parameter logic [15:0] LEN2       = 16'h0589,
    parameter logic [15:0] LEN3       = 16'h0AE1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       bgm_enable,
    input  logic [3:0] req_valid,
    input  logic [7:0] req_id,
    input  logic       sample_tick,
    output logic [2:0] audio_ctrl,
    output logic       sfx_active,
    output logic [3:0] pending,
    output logic [7:0] drop_count
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GAP  = 2'd1,
        ST_PLAY = 2'd2
    } state_t;

    // Last value of the gap counter before moving on to PLAY.
    localparam logic [15:0] GAP_LAST = 16'(GAP_CYCLES - 32'd1);

    // Sample count of a given effect id.
    function automatic logic [15:0] effect_len(input logic [1:0] id);
        case (id)
            2'd1:    effect_len = LEN1;
            2'd2:    effect_len = LEN2;
            2'd3:    effect_len = LEN3;
            default: effect_len = 16'd1;
        endcase
    endfunction

    state_t          state_q, state_d;
    logic [3:0]      pend_q, pend_d;
    logic [3:0][1:0] ids_q, ids_d;
    logic [1:0]      rr_q, rr_d;
    logic [1:0]      cur_id_q, cur_id_d;
    logic [15:0]     gap_cnt_q, gap_cnt_d;
    logic [15:0]     smp_cnt_q, smp_cnt_d;
    logic [7:0]      drop_q, drop_d;
    logic            bgm_q;
    logic [1:0]      sel_q, sel_d;
    logic            active_q, active_d;

    logic            found_s;
    logic [1:0]      win_s;
    logic            grant_s;
    logic [3:0]      grant_vec_s;
    logic [2:0]      drop_inc_s;
    logic [8:0]      drop_sum_s;

    // Round-robin winner search starting at rr_q; a grant only happens in IDLE.
    always_comb begin
        found_s = 1'b0;
        win_s   = rr_q;
        for (int k = 0; k < 4; k++) begin
            if (!found_s && pend_q[rr_q + 2'(k)]) begin
                found_s = 1'b1;
                win_s   = rr_q + 2'(k);
            end else begin
                found_s = found_s;
            end
        end
        grant_s     = (state_q == ST_IDLE) && (pend_q != 4'b0000);
        grant_vec_s = grant_s ? (4'b0001 << win_s) : 4'b0000;
    end

    // Pending slots and drop counting. A new request on the granted slot
    // refills it after the old entry has been consumed, so it is not a drop.
    always_comb begin
        pend_d     = pend_q;
        ids_d      = ids_q;
        drop_inc_s = 3'd0;
        for (int i = 0; i < 4; i++) begin
            if (req_valid[i] && (req_id[2*i +: 2] != 2'd0)) begin
                pend_d[i] = 1'b1;
                ids_d[i]  = req_id[2*i +: 2];
                if (pend_q[i] && !grant_vec_s[i]) begin
                    drop_inc_s = drop_inc_s + 3'd1;
                end else begin
                    drop_inc_s = drop_inc_s;
                end
            end else begin
                pend_d[i] = pend_q[i] && !grant_vec_s[i];
            end
        end
        drop_sum_s = {1'b0, drop_q} + {6'd0, drop_inc_s};
        drop_d     = (drop_sum_s > 9'd255) ? 8'd255 : drop_sum_s[7:0];
    end

    // Next-state logic of the IDLE / GAP / PLAY sequencer.
    always_comb begin
        state_d   = state_q;
        rr_d      = rr_q;
        cur_id_d  = cur_id_q;
        gap_cnt_d = gap_cnt_q;
        smp_cnt_d = smp_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_s) begin
                    state_d   = ST_GAP;
                    cur_id_d  = ids_q[win_s];
                    rr_d      = win_s + 2'd1;
                    gap_cnt_d = 16'd0;
                end else begin
                    state_d   = ST_IDLE;
                end
            end
            ST_GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    state_d   = ST_PLAY;
                    smp_cnt_d = 16'd0;
                end else begin
                    gap_cnt_d = gap_cnt_q + 16'd1;
                end
            end
            ST_PLAY: begin
                if (sample_tick) begin
                    smp_cnt_d = smp_cnt_q + 16'd1;
                    if ((smp_cnt_q + 16'd1) == effect_len(cur_id_q)) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_PLAY;
                    end
                end else begin
                    smp_cnt_d = smp_cnt_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output decode from the next state so the outputs can be registered
    // in step with the state. IDLE keeps the last id to avoid a spurious edge.
    always_comb begin
        if (state_d == ST_GAP) begin
            sel_d = 2'd0;
        end else begin
            sel_d = cur_id_d;
        end
        active_d = (state_d == ST_PLAY);
    end

    // Sequencer state, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            rr_q      <= 2'd0;
            cur_id_q  <= 2'd0;
            gap_cnt_q <= 16'd0;
            smp_cnt_q <= 16'd0;
            sel_q     <= 2'd0;
            active_q  <= 1'b0;
            bgm_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            rr_q      <= rr_d;
            cur_id_q  <= cur_id_d;
            gap_cnt_q <= gap_cnt_d;
            smp_cnt_q <= smp_cnt_d;
            sel_q     <= sel_d;
            active_q  <= active_d;
            bgm_q     <= bgm_enable;
        end
    end

    // Request slots and drop counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            pend_q <= 4'b0000;
            ids_q  <= '0;
            drop_q <= 8'd0;
        end else begin
            pend_q <= pend_d;
            ids_q  <= ids_d;
            drop_q <= drop_d;
        end
    end

    assign audio_ctrl = {bgm_q, sel_q};
    assign sfx_active = active_q;
    assign pending    = pend_q;
    assign drop_count = drop_q;

endmodule

// File: tb/tb_sfx_scheduler.sv
module tb_sfx_scheduler;

    localparam int GAP  = 4;
    localparam int L1   = 5482;   // 16'h156A
    localparam int L2   = 1417;   // 16'h0589
    localparam int L3   = 2785;   // 16'h0AE1

    logic       clk = 1'b0;
    logic       reset;
    logic       bgm_enable;
    logic [3:0] req_valid;
    logic [7:0] req_id;
    logic       sample_tick;
    logic [2:0] audio_ctrl;
    logic       sfx_active;
    logic [3:0] pending;
    logic [7:0] drop_count;

    always #5 clk = ~clk;

    sfx_scheduler dut (
        .clk         (clk),
        .reset       (reset),
        .bgm_enable  (bgm_enable),
        .req_valid   (req_valid),
        .req_id      (req_id),
        .sample_tick (sample_tick),
        .audio_ctrl  (audio_ctrl),
        .sfx_active  (sfx_active),
        .pending     (pending),
        .drop_count  (drop_count)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    bit rst_lvl = 1'b0;
    bit bgm_lvl = 1'b0;

    // Reference model: slot table plus remaining-gap / remaining-sample counts.
    bit m_pend [4];
    int m_id   [4];
    int m_start;
    int m_cur;
    int m_gap_left;
    int m_play_left;
    int m_drops;
    bit m_bgm;

    function automatic int len_of(input int id);
        case (id)
            1:       return L1;
            2:       return L2;
            3:       return L3;
            default: return 1;
        endcase
    endfunction

    task automatic model_edge(input bit rst, input bit bgm, input logic [3:0] v,
                              input logic [7:0] ids, input bit tick);
        int win;
        int idv;
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                m_pend[i] = 1'b0;
                m_id[i]   = 0;
            end
            m_start = 0; m_cur = 0; m_gap_left = 0; m_play_left = 0;
            m_drops = 0; m_bgm = 1'b0;
        end else begin
            win = -1;
            if (m_gap_left == 0 && m_play_left == 0) begin
                for (int k = 0; k < 4; k++) begin
                    if (win < 0 && m_pend[(m_start + k) % 4]) win = (m_start + k) % 4;
                end
            end
            for (int i = 0; i < 4; i++) begin
                idv = int'((ids >> (2 * i)) & 8'd3);
                if (v[i] && idv != 0 && m_pend[i] && i != win && m_drops < 255) m_drops++;
            end
            if (win >= 0) begin
                m_cur = m_id[win];
                m_pend[win] = 1'b0;
                m_start = (win + 1) % 4;
            end
            for (int i = 0; i < 4; i++) begin
                idv = int'((ids >> (2 * i)) & 8'd3);
                if (v[i] && idv != 0) begin
                    m_pend[i] = 1'b1;
                    m_id[i]   = idv;
                end
            end
            if (m_gap_left > 0) begin
                m_gap_left--;
                if (m_gap_left == 0) m_play_left = len_of(m_cur);
            end else if (m_play_left > 0) begin
                if (tick) m_play_left--;
            end else if (win >= 0) begin
                m_gap_left = GAP;
            end
            m_bgm = bgm;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: apply inputs, let the edge happen, advance model, compare.
    task automatic cyc(input logic [3:0] v, input logic [7:0] ids, input bit tick);
        logic [2:0] exp_ctrl;
        logic [3:0] exp_pend;
        reset = rst_lvl; bgm_enable = bgm_lvl; req_valid = v; req_id = ids; sample_tick = tick;
        @(posedge clk);
        #1;
        model_edge(rst_lvl, bgm_lvl, v, ids, tick);
        exp_ctrl[2]   = m_bgm;
        exp_ctrl[1:0] = (m_gap_left > 0) ? 2'd0 : 2'(m_cur);
        exp_pend      = {m_pend[3], m_pend[2], m_pend[1], m_pend[0]};
        chk("audio_ctrl", {29'd0, audio_ctrl}, {29'd0, exp_ctrl});
        chk("sfx_active", {31'd0, sfx_active}, {31'd0, (m_play_left > 0)});
        chk("pending", {28'd0, pending}, {28'd0, exp_pend});
        chk("drop_count", {24'd0, drop_count}, m_drops);
    endtask

    task automatic run(input int n, input bit tick);
        repeat (n) cyc(4'b0000, 8'h00, tick);
    endtask

    initial begin
        // Reset with requests present: they must be discarded.
        rst_lvl = 1'b1;
        cyc(4'b1111, 8'hFF, 1'b1);
        cyc(4'b1111, 8'hFF, 1'b1);
        chk("reset_ctrl", {29'd0, audio_ctrl}, 32'd0);
        chk("reset_pend", {28'd0, pending}, 32'd0);
        rst_lvl = 1'b0;
        run(1, 1'b0);

        // Background music path: one cycle of latency, select untouched.
        bgm_lvl = 1'b1;
        cyc(4'b0000, 8'h00, 1'b0);
        chk("bgm_on", {29'd0, audio_ctrl}, 32'h4);

        // Single request of id 2 from requester 1 with exact boundaries.
        cyc(4'b0010, 8'b0000_1000, 1'b1);
        chk("latch_pend", {28'd0, pending}, 32'h2);
        cyc(4'b0000, 8'h00, 1'b1);
        chk("gap_start", {30'd0, audio_ctrl[1:0]}, 32'd0);
        run(GAP - 1, 1'b1);
        chk("gap_end", {30'd0, audio_ctrl[1:0]}, 32'd0);
        run(1, 1'b1);
        chk("play_sel", {29'd0, audio_ctrl}, 32'h6);
        chk("play_act", {31'd0, sfx_active}, 32'd1);
        run(L2 - 1, 1'b1);
        chk("play_last", {31'd0, sfx_active}, 32'd1);
        run(1, 1'b1);
        chk("idle_act", {31'd0, sfx_active}, 32'd0);
        chk("idle_keep", {29'd0, audio_ctrl}, 32'h6);

        // Three simultaneous requests from a fresh round-robin pointer.
        rst_lvl = 1'b1; run(2, 1'b0); rst_lvl = 1'b0;
        cyc(4'b1101, 8'b1111_0011, 1'b1);
        chk("rr_latch", {28'd0, pending}, 32'hD);
        cyc(4'b0000, 8'h00, 1'b1);
        chk("rr_grant0", {28'd0, pending}, 32'hC);
        run(GAP + L3, 1'b1);
        cyc(4'b0000, 8'h00, 1'b1);
        chk("rr_grant2", {28'd0, pending}, 32'h8);
        run(GAP + L3, 1'b1);
        cyc(4'b0000, 8'h00, 1'b1);
        chk("rr_grant3", {28'd0, pending}, 32'h0);
        run(GAP + L3 + 2, 1'b1);

        // Request on the same requester's grant cycle: refill, no drop.
        cyc(4'b0001, 8'h01, 1'b0);
        cyc(4'b0001, 8'h02, 1'b0);
        chk("regrant_pend", {28'd0, pending}, 32'h1);
        chk("regrant_drop", {24'd0, drop_count}, 32'd0);
        run(10, 1'b1);
        rst_lvl = 1'b1; run(2, 1'b0); rst_lvl = 1'b0;

        // Overwrite while pending, then saturate the drop counter.
        cyc(4'b0001, 8'h02, 1'b1);
        cyc(4'b0000, 8'h00, 1'b1);
        cyc(4'b0010, 8'b0000_0100, 1'b1);
        cyc(4'b0010, 8'b0000_1100, 1'b1);
        chk("drop_one", {24'd0, drop_count}, 32'd1);
        run(L2 + 13, 1'b1);
        chk("play_id3", {30'd0, audio_ctrl[1:0]}, 32'd3);
        for (int n = 0; n < 300; n++) begin
            cyc(4'b0010, (n % 2 == 1) ? 8'b0000_0100 : 8'b0000_1000, 1'b1);
        end
        chk("drop_sat", {24'd0, drop_count}, 32'd255);
        rst_lvl = 1'b1; run(2, 1'b0); rst_lvl = 1'b0;

        // Reset in the middle of PLAY, then a normal effect afterwards.
        cyc(4'b0100, 8'b0010_0000, 1'b0);
        run(5, 1'b0);
        chk("pre_play", {31'd0, sfx_active}, 32'd1);
        cyc(4'b1000, 8'b1100_0000, 1'b1);
        run(99, 1'b1);
        chk("mid_pend", {28'd0, pending}, 32'h8);
        rst_lvl = 1'b1;
        cyc(4'b0000, 8'h00, 1'b1);
        rst_lvl = 1'b0;
        chk("abort_ctrl", {29'd0, audio_ctrl}, 32'd0);
        chk("abort_pend", {28'd0, pending}, 32'd0);
        chk("abort_act", {31'd0, sfx_active}, 32'd0);
        cyc(4'b0100, 8'b0010_0000, 1'b0);
        run(6, 1'b1);
        chk("replay_sel", {30'd0, audio_ctrl[1:0]}, 32'd2);
        run(L2, 1'b1);
        chk("replay_done", {31'd0, sfx_active}, 32'd0);

        // Randomized traffic against the model.
        for (int n = 0; n < 15000; n++) begin
            logic [3:0] v;
            logic [7:0] ids;
            rst_lvl = ($urandom_range(0, 2999) == 0);
            if ($urandom_range(0, 199) == 0) bgm_lvl = ~bgm_lvl;
            for (int i = 0; i < 4; i++) v[i] = ($urandom_range(0, 19) == 0);
            ids = 8'($urandom);
            cyc(v, ids, ($urandom_range(0, 7) != 0));
        end
        rst_lvl = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
